// File: rtl/inst_fetch_way0.sv
// ============================================================================
// Module   : inst_fetch_way0
// Purpose  : Way-0 fetch stage. Takes PC-unit addresses, issues in-order
//            instruction-memory requests and buffers returned packets for
//            decode. Optional FETCH_PERF_CNT_EN adds stall/drop counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch_way0 #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  input  logic [31:0] instAddr_i,
  output logic        ready_o,
  input  logic        jumpFlag_i,
  output logic        memReqValid_o,
  output logic [31:0] memReqAddr_o,
  input  logic        memReqReady_i,
  input  logic        memRespValid_i,
  input  logic [63:0] memRespData_i,
  output logic        instValid_o,
  output logic [31:0] instPc_o,
  output logic [31:0] inst0_o,
  output logic [31:0] inst1_o,
  output logic [1:0]  instMask_o,
  input  logic        decodeReady_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perfStallCnt_o,
  output logic [31:0] perfDropCnt_o
`endif
);

  localparam int               c_AW    = $clog2(FIFO_DEPTH);
  localparam logic [c_AW+1:0]  c_DEPTH = (c_AW+2)'(FIFO_DEPTH);

  logic [c_AW:0]           r_alloc;
  logic [c_AW:0]           r_fill;
  logic [c_AW:0]           r_read;
  logic [c_AW:0]           r_drop;
  logic [31:0]             r_pc   [FIFO_DEPTH];
  logic [63:0]             r_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   r_filled;

  logic [c_AW:0]           w_count;
  logic [c_AW:0]           w_unfilled;
  logic [c_AW+1:0]         w_occ;
  logic                    w_credit;
  logic                    w_drop_nz;
  logic                    w_unf_nz;
  logic                    w_resp_drop;
  logic                    w_resp_write;
  logic                    w_discard;
  logic                    w_pop;
  logic                    w_head_filled;
  logic [c_AW-1:0]         w_al_idx;
  logic [c_AW-1:0]         w_fl_idx;
  logic [c_AW-1:0]         w_rd_idx;
  logic [FIFO_DEPTH-1:0]   w_set_mask;
  logic [FIFO_DEPTH-1:0]   w_clr_mask;

  assign w_count    = r_alloc - r_read;
  assign w_unfilled = r_alloc - r_fill;
  // Dropped-but-not-yet-returned responses still hold a credit.
  assign w_occ      = {1'b0, w_count} + {1'b0, r_drop};
  assign w_credit   = (w_occ < c_DEPTH);

  assign w_al_idx = r_alloc[c_AW-1:0];
  assign w_fl_idx = r_fill[c_AW-1:0];
  assign w_rd_idx = r_read[c_AW-1:0];

  assign memReqValid_o = valid_i & w_credit & ~jumpFlag_i;
  assign ready_o       = memReqValid_o & memReqReady_i;
  assign memReqAddr_o  = {instAddr_i[31:3], 3'b000};

  assign w_drop_nz    = (r_drop != '0);
  assign w_unf_nz     = (w_unfilled != '0);
  assign w_resp_drop  = memRespValid_i & w_drop_nz;
  assign w_resp_write = memRespValid_i & ~w_drop_nz & w_unf_nz & ~jumpFlag_i;
  // A response landing in the flush cycle belongs to a now-stale request.
  assign w_discard    = memRespValid_i & (w_drop_nz | (jumpFlag_i & w_unf_nz));

  assign w_head_filled = r_filled[w_rd_idx];
  assign instValid_o   = w_head_filled & ~jumpFlag_i;
  assign w_pop         = instValid_o & decodeReady_i;

  assign instPc_o   = r_pc[w_rd_idx];
  assign inst0_o    = r_data[w_rd_idx][31:0];
  assign inst1_o    = r_data[w_rd_idx][63:32];
  assign instMask_o = !w_head_filled       ? 2'b00 :
                      r_pc[w_rd_idx][2]    ? 2'b10 : 2'b11;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (ready_o)      w_clr_mask[w_al_idx] = 1'b1;
    if (w_pop)        w_clr_mask[w_rd_idx] = 1'b1;
    if (w_resp_write) w_set_mask[w_fl_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alloc  <= '0;
      r_fill   <= '0;
      r_read   <= '0;
      r_drop   <= '0;
      r_filled <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (ready_o)      r_pc[w_al_idx]   <= instAddr_i;
      if (w_resp_write) r_data[w_fl_idx] <= memRespData_i;
      if (jumpFlag_i) begin
        r_drop   <= r_drop + w_unfilled - {{c_AW{1'b0}}, w_discard};
        r_fill   <= r_alloc;
        r_read   <= r_alloc;
        r_filled <= '0;
      end else begin
        if (ready_o)      r_alloc <= r_alloc + 1'b1;
        if (w_resp_drop)  r_drop  <= r_drop - 1'b1;
        if (w_resp_write) r_fill  <= r_fill + 1'b1;
        if (w_pop)        r_read  <= r_read + 1'b1;
        r_filled <= (r_filled & ~w_clr_mask) | w_set_mask;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (valid_i & ~jumpFlag_i & ~ready_o) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_discard)                        r_drop_cnt  <= r_drop_cnt + 32'd1;
    end
  end

  assign perfStallCnt_o = r_stall_cnt;
  assign perfDropCnt_o  = r_drop_cnt;
`endif

  a_resp_expected: assert property (@(posedge clk) disable iff (!reset_n)
    memRespValid_i |-> (w_drop_nz || w_unf_nz));

  a_addr_aligned: assert property (@(posedge clk) disable iff (!reset_n)
    valid_i |-> (instAddr_i[1:0] == 2'b00));

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_way0.sv
// ============================================================================
// Module   : tb_inst_fetch_way0
// Purpose  : Self-checking bench for inst_fetch_way0 (queue reference model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch_way0;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i, ready_o, jumpFlag_i, memReqValid_o, memReqReady_i;
  logic        memRespValid_i, instValid_o, decodeReady_i;
  logic [31:0] instAddr_i, memReqAddr_o, instPc_o, inst0_o, inst1_o;
  logic [63:0] memRespData_i;
  logic [1:0]  instMask_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfStallCnt_o, perfDropCnt_o;
`endif

  inst_fetch_way0 #(.FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .instAddr_i(instAddr_i),
    .ready_o(ready_o), .jumpFlag_i(jumpFlag_i), .memReqValid_o(memReqValid_o),
    .memReqAddr_o(memReqAddr_o), .memReqReady_i(memReqReady_i),
    .memRespValid_i(memRespValid_i), .memRespData_i(memRespData_i),
    .instValid_o(instValid_o), .instPc_o(instPc_o), .inst0_o(inst0_o),
    .inst1_o(inst1_o), .instMask_o(instMask_o), .decodeReady_i(decodeReady_i)
`ifdef FETCH_PERF_CNT_EN
    , .perfStallCnt_o(perfStallCnt_o), .perfDropCnt_o(perfDropCnt_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of fetch entries plus an outstanding-drop count.
  typedef struct {
    logic [31:0] pc;
    logic [63:0] data;
    bit          filled;
  } ent_t;
  ent_t q[$];
  int   drop, stall_cnt, dropped_cnt;

  // Memory model: in-order pending requests with due cycle.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0, lat = 1, last_due = -1;

  logic        s_rdy, s_iv;
  logic [31:0] s_pc, s_maddr;
  logic [1:0]  s_mask;

  function automatic logic [63:0] pkt(input logic [31:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; valid_i = 1'b0; jumpFlag_i = 1'b0; memReqReady_i = 1'b1;
    decodeReady_i = 1'b0; instAddr_i = '0; memRespValid_i = 1'b0; memRespData_i = '0;
    @(negedge clk); @(negedge clk);
    q.delete(); mq_addr.delete(); mq_due.delete();
    drop = 0; stall_cnt = 0; dropped_cnt = 0; last_due = -1;
    reset_n = 1'b1;
  endtask

  // One clock cycle: called at a negedge with the caller's inputs already set.
  task automatic step();
    bit e_mrv, e_rdy, e_iv, hs;
    int fi, outst, due;
    memRespValid_i = 1'b0;
    memRespData_i  = '0;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      memRespValid_i = 1'b1;
      memRespData_i  = pkt(mq_addr[0]);
    end
    #1;
    e_mrv = valid_i && ((q.size() + drop) < DEPTH) && !jumpFlag_i;
    e_rdy = e_mrv && memReqReady_i;
    e_iv  = (q.size() > 0) && q[0].filled && !jumpFlag_i;
    chk("memReqValid", 64'(memReqValid_o), 64'(e_mrv));
    chk("ready", 64'(ready_o), 64'(e_rdy));
    chk("memReqAddr", 64'(memReqAddr_o), 64'(instAddr_i & 32'hFFFF_FFF8));
    chk("instValid", 64'(instValid_o), 64'(e_iv));
    if (e_iv) begin
      chk("instPc", 64'(instPc_o), 64'(q[0].pc));
      chk("inst0", 64'(inst0_o), 64'(q[0].data[31:0]));
      chk("inst1", 64'(inst1_o), 64'(q[0].data[63:32]));
      chk("instMask", 64'(instMask_o), q[0].pc[2] ? 64'd2 : 64'd3);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perfStall", 64'(perfStallCnt_o), 64'(stall_cnt));
    chk("perfDrop", 64'(perfDropCnt_o), 64'(dropped_cnt));
`endif
    s_rdy = ready_o; s_iv = instValid_o; s_pc = instPc_o; s_mask = instMask_o;
    s_maddr = memReqAddr_o;
    hs = memReqValid_o && memReqReady_i;
    @(posedge clk);
    if (memRespValid_i) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (hs) begin
      due = cyc + lat;
      if (mq_due.size() > 0 && due <= last_due) due = last_due + 1;
      mq_addr.push_back(instAddr_i);
      mq_due.push_back(due);
      last_due = due;
    end
    if (jumpFlag_i) begin
      outst = drop;
      foreach (q[i]) if (!q[i].filled) outst++;
      if (memRespValid_i && outst > 0) begin outst--; dropped_cnt++; end
      drop = outst;
      q.delete();
    end else begin
      if (memRespValid_i) begin
        if (drop > 0) begin
          drop--; dropped_cnt++;
        end else begin
          fi = -1;
          for (int i = 0; i < q.size(); i++) if (!q[i].filled) begin fi = i; break; end
          if (fi >= 0) begin q[fi].filled = 1'b1; q[fi].data = memRespData_i; end
        end
      end
      if (e_iv && decodeReady_i) void'(q.pop_front());
      if (e_rdy) q.push_back('{instAddr_i, 64'd0, 1'b0});
    end
    if (valid_i && !jumpFlag_i && !e_rdy) stall_cnt++;
    cyc++;
    @(negedge clk);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic        j;
    logic        mrr;
    logic        e_mrv;
    logic        e_rdy;
    logic [31:0] e_addr;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int          first_acc, first_iv, n_iv, nacc, nrdy;
    logic [31:0] pc, fpc;
    logic [1:0]  fmask;
    bit          got;

    tbl[0] = '{1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000};
    tbl[1] = '{1'b1, 32'h0000_0104, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
    tbl[2] = '{1'b1, 32'h0000_010C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0108};
    tbl[3] = '{1'b0, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0020};
    tbl[4] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8};
    tbl[5] = '{1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678};

    // Reset state and empty-FIFO request path, held in reset.
    reset_n = 1'b0; decodeReady_i = 1'b1; memRespValid_i = 1'b0; memRespData_i = '0;
    for (int i = 0; i < 6; i++) begin
      valid_i = tbl[i].v; instAddr_i = tbl[i].a; jumpFlag_i = tbl[i].j;
      memReqReady_i = tbl[i].mrr;
      #1;
      chk("tbl_memReqValid", 64'(memReqValid_o), 64'(tbl[i].e_mrv));
      chk("tbl_ready", 64'(ready_o), 64'(tbl[i].e_rdy));
      chk("tbl_memReqAddr", 64'(memReqAddr_o), 64'(tbl[i].e_addr));
      chk("tbl_instValid", 64'(instValid_o), 64'd0);
    end
    chk("rst_instMask", 64'(instMask_o), 64'd0);
    chk("rst_instPc", 64'(instPc_o), 64'd0);
    chk("rst_inst0", 64'(inst0_o), 64'd0);
    chk("rst_inst1", 64'(inst1_o), 64'd0);

    // Streaming at latency 2.
    do_reset();
    lat = 2; memReqReady_i = 1'b1; decodeReady_i = 1'b1; valid_i = 1'b1; pc = 0;
    first_acc = -1; first_iv = -1; n_iv = 0; fpc = 'x; fmask = 'x;
    for (int k = 0; k < 12; k++) begin
      instAddr_i = pc; step();
      if (s_rdy && first_acc < 0) first_acc = k;
      if (s_iv) begin
        if (first_iv < 0) begin first_iv = k; fpc = s_pc; fmask = s_mask; end
        n_iv++;
      end
      if (s_rdy) pc += 8;
    end
    chk("stream_first_acc", 64'(first_acc), 64'd0);
    chk("stream_first_valid", 64'(first_iv - first_acc), 64'd3);
    chk("stream_first_pc", 64'(fpc), 64'd0);
    chk("stream_first_mask", 64'(fmask), 64'd3);
    chk("stream_packets", 64'(n_iv), 64'd9);

    // Backpressure to full.
    do_reset();
    lat = 1; decodeReady_i = 1'b0; valid_i = 1'b1; pc = 0; nacc = 0;
    for (int k = 0; k < 8; k++) begin
      instAddr_i = pc; step();
      if (s_rdy) begin nacc++; pc += 8; end
    end
    chk("bp_accepts", 64'(nacc), 64'd4);
    chk("bp_pc_held", 64'(pc), 64'h20);
    chk("bp_full_ready", 64'(s_rdy), 64'd0);
    decodeReady_i = 1'b1; instAddr_i = pc; step();
    chk("bp_pop_cycle_ready", 64'(s_rdy), 64'd0);
    chk("bp_pop_valid", 64'(s_iv), 64'd1);
    decodeReady_i = 1'b0; step();
    chk("bp_reenable", 64'(s_rdy), 64'd1);

    // Jump flush with three requests outstanding.
    do_reset();
    lat = 5; decodeReady_i = 1'b1; valid_i = 1'b1; pc = 0;
    for (int k = 0; k < 3; k++) begin
      instAddr_i = pc; step();
      if (s_rdy) pc += 8;
    end
    jumpFlag_i = 1'b1; instAddr_i = 32'h104; step();
    chk("jump_ready", 64'(s_rdy), 64'd0);
    jumpFlag_i = 1'b0; pc = 32'h104; got = 1'b0;
    for (int k = 0; k < 15; k++) begin
      instAddr_i = pc; step();
      if (k == 0) chk("jump_req_addr", 64'(s_maddr), 64'h100);
      if (s_iv && !got) begin
        got = 1'b1;
        chk("jump_pc", 64'(s_pc), 64'h104);
        chk("jump_mask", 64'(s_mask), 64'd2);
      end
      if (s_rdy) pc += 8;
    end
    chk("jump_packet_seen", 64'(got), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_drop_after_flush", 64'(perfDropCnt_o), 64'd3);
`endif

    // Flush with a coincident response and two unfilled entries.
    do_reset();
    decodeReady_i = 1'b1; valid_i = 1'b1; pc = 0;
    for (int k = 0; k < 3; k++) begin
      lat = (k == 2) ? 10 : 3;
      instAddr_i = pc; step();
      if (s_rdy) pc += 8;
    end
    valid_i = 1'b0; step();
    jumpFlag_i = 1'b1; step();
    chk("coinc_jump_valid", 64'(s_iv), 64'd0);
    jumpFlag_i = 1'b0; valid_i = 1'b1; decodeReady_i = 1'b0; lat = 30;
    pc = 32'h200; nacc = 0;
    for (int k = 5; k < 15; k++) begin
      instAddr_i = pc; step();
      if (k == 5) chk("coinc_after_valid", 64'(s_iv), 64'd0);
      if (k == 11) chk("coinc_credit_accepts", 64'(nacc), 64'd3);
      if (k == 13) chk("coinc_drop_released", 64'(s_rdy), 64'd1);
      if (s_rdy) begin nacc++; pc += 8; end
    end

    // Memory stall for five cycles.
    do_reset();
    lat = 1; decodeReady_i = 1'b1; valid_i = 1'b1; pc = 0;
    for (int k = 0; k < 2; k++) begin
      instAddr_i = pc; step();
      if (s_rdy) pc += 8;
    end
    memReqReady_i = 1'b0; nrdy = 0;
    for (int k = 0; k < 5; k++) begin
      instAddr_i = pc; step();
      if (s_rdy) begin nrdy++; pc += 8; end
    end
    chk("stall_ready", 64'(nrdy), 64'd0);
    chk("stall_addr", 64'(s_maddr), 64'h10);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall_count", 64'(perfStallCnt_o), 64'd5);
`endif
    memReqReady_i = 1'b1; instAddr_i = pc; step();
    chk("resume_ready", 64'(s_rdy), 64'd1);
    chk("resume_addr", 64'(s_maddr), 64'h10);

    // Randomized traffic against the reference model.
    do_reset();
    pc = 32'h1000;
    for (int k = 0; k < 3000; k++) begin
      lat           = int'($urandom_range(1, 4));
      valid_i       = ($urandom_range(0, 99) < 80);
      jumpFlag_i    = ($urandom_range(0, 99) < 5);
      memReqReady_i = ($urandom_range(0, 99) < 70);
      decodeReady_i = ($urandom_range(0, 99) < 60);
      instAddr_i    = pc;
      step();
      if (jumpFlag_i) pc = $urandom() & 32'hFFFF_FFFC;
      else if (s_rdy) pc += 8;
    end
    jumpFlag_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
